// File: rtl/snd_latch_irq_if.sv
// rtl/snd_latch_irq_if.sv - main/sound/Z80 bus bundle for the sound command latch
interface snd_latch_irq_if;
    logic       main_wr;
    logic [7:0] main_din;
    logic       main_rd;
    logic [7:0] main_dout;
    logic       main_pending;
    logic       snd_rd;
    logic [7:0] snd_dout;
    logic       snd_clr;
    logic       snd_reply_wr;
    logic [7:0] snd_din;
    logic       ym_irq_n;
    logic       z80_m1_n;
    logic       z80_iorq_n;
    logic       z80_int_n;
    logic [7:0] int_vector;

    modport master (
        output main_wr, main_din, main_rd, snd_rd, snd_clr, snd_reply_wr,
               snd_din, ym_irq_n, z80_m1_n, z80_iorq_n,
        input  main_dout, main_pending, snd_dout, z80_int_n, int_vector
    );

    modport slave (
        input  main_wr, main_din, main_rd, snd_rd, snd_clr, snd_reply_wr,
               snd_din, ym_irq_n, z80_m1_n, z80_iorq_n,
        output main_dout, main_pending, snd_dout, z80_int_n, int_vector
    );
endinterface

// File: rtl/snd_latch_irq.sv
// rtl/snd_latch_irq.sv - main->sound command latch, reply port and Z80 INT/RST vector merge
// Optional 4-deep command FIFO when SND_LATCH_FIFO_EN is defined.
module snd_latch_irq #(
    parameter logic [7:0] VEC_IDLE  = 8'hFF,
    parameter int         LATCH_BIT = 5,
    parameter int         YM_BIT    = 4
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    snd_latch_irq_if.slave bus
);
    logic main_wr_q, main_rd_q, snd_rd_q, snd_clr_q, snd_reply_wr_q;
    logic wr_rise, clr_rise, reply_rise;
    logic [7:0] reply;
    logic pending;
    logic int_n_q;
    logic ack, ack_q;
    logic [7:0] ack_vec;
    logic [7:0] live_vec;

    // Reads are edge-tracked like the other strobes but have no side effect.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            main_wr_q      <= 1'b0;
            main_rd_q      <= 1'b0;
            snd_rd_q       <= 1'b0;
            snd_clr_q      <= 1'b0;
            snd_reply_wr_q <= 1'b0;
        end else begin
            main_wr_q      <= bus.main_wr;
            main_rd_q      <= bus.main_rd;
            snd_rd_q       <= bus.snd_rd;
            snd_clr_q      <= bus.snd_clr;
            snd_reply_wr_q <= bus.snd_reply_wr;
        end
    end

    assign wr_rise    = bus.main_wr & ~main_wr_q;
    assign clr_rise   = bus.snd_clr & ~snd_clr_q;
    assign reply_rise = bus.snd_reply_wr & ~snd_reply_wr_q;

`ifdef SND_LATCH_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic       push_ok, pop_ok;

    // At count=0 the pop is refused, so a same-clock push lands as the new head.
    assign push_ok = wr_rise & (count != 3'd4);
    assign pop_ok  = clr_rise & (count != 3'd0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= bus.main_din;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign pending      = (count != 3'd0);
    assign bus.snd_dout = pending ? fifo_mem[rd_ptr] : 8'h00;
`else
    logic [7:0] cmd;
    logic       pending_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmd       <= 8'h00;
            pending_q <= 1'b0;
        end else if (wr_rise) begin
            cmd       <= bus.main_din;
            pending_q <= 1'b1;
        end else if (clr_rise) begin
            pending_q <= 1'b0;
        end
    end

    assign pending      = pending_q;
    assign bus.snd_dout = cmd;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) reply <= 8'hFF;
        else if (reply_rise) reply <= bus.snd_din;
    end

    assign bus.main_dout    = reply;
    assign bus.main_pending = pending;

    always_comb begin
        live_vec = VEC_IDLE;
        if (pending)       live_vec[LATCH_BIT] = 1'b0;
        if (!bus.ym_irq_n) live_vec[YM_BIT]    = 1'b0;
    end

    assign ack = ~bus.z80_m1_n & ~bus.z80_iorq_n;

    // Vector is captured once per acknowledge window so a mid-cycle source change cannot corrupt it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            int_n_q <= 1'b1;
            ack_q   <= 1'b0;
            ack_vec <= VEC_IDLE;
        end else begin
            int_n_q <= ~(pending | ~bus.ym_irq_n);
            ack_q   <= ack;
            if (ack && !ack_q) ack_vec <= live_vec;
        end
    end

    assign bus.z80_int_n  = int_n_q;
    assign bus.int_vector = ack ? ack_vec : VEC_IDLE;
endmodule

// File: tb/tb_snd_latch_irq.sv
// tb/tb_snd_latch_irq.sv - directed self-checking bench for snd_latch_irq
module tb_snd_latch_irq;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    snd_latch_irq_if bus ();

    snd_latch_irq dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        bus.main_wr = 0; bus.main_din = 0; bus.main_rd = 0; bus.snd_rd = 0;
        bus.snd_clr = 0; bus.snd_reply_wr = 0; bus.snd_din = 0;
        bus.ym_irq_n = 1; bus.z80_m1_n = 1; bus.z80_iorq_n = 1;
        reset_n = 0;
        tick(); tick();
        checks++; if (bus.snd_dout !== 8'h00) begin errors++; $display("FAIL reset_snd_dout got %h want 00", bus.snd_dout); end
        checks++; if (bus.main_dout !== 8'hFF) begin errors++; $display("FAIL reset_main_dout got %h want FF", bus.main_dout); end
        checks++; if (bus.main_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", bus.main_pending); end
        checks++; if (bus.z80_int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got %b want 1", bus.z80_int_n); end
        checks++; if (bus.int_vector !== 8'hFF) begin errors++; $display("FAIL reset_vector got %h want FF", bus.int_vector); end
        reset_n = 1;
        tick();
    endtask

`ifndef SND_LATCH_FIFO_EN
    task automatic test_cmd_write();
        bus.main_din = 8'h3A; bus.main_wr = 1;
        tick();
        checks++; if (bus.snd_dout !== 8'h3A) begin errors++; $display("FAIL write_cmd got %h want 3A", bus.snd_dout); end
        checks++; if (bus.main_pending !== 1'b1) begin errors++; $display("FAIL write_pending got %b want 1", bus.main_pending); end
        checks++; if (bus.z80_int_n !== 1'b1) begin errors++; $display("FAIL write_int_latency got %b want 1", bus.z80_int_n); end
        bus.main_din = 8'h77;
        tick();
        checks++; if (bus.z80_int_n !== 1'b0) begin errors++; $display("FAIL write_int_n got %b want 0", bus.z80_int_n); end
        tick(); tick(); tick();
        checks++; if (bus.snd_dout !== 8'h3A) begin errors++; $display("FAIL write_held_once got %h want 3A", bus.snd_dout); end
        bus.main_wr = 0;
        bus.snd_rd = 1; tick(); bus.snd_rd = 0; tick();
        checks++; if (bus.main_pending !== 1'b1) begin errors++; $display("FAIL read_no_clear got %b want 1", bus.main_pending); end
    endtask

    task automatic test_ack();
        bus.z80_m1_n = 0; bus.z80_iorq_n = 0;
        tick();
        checks++; if (bus.int_vector !== 8'hDF) begin errors++; $display("FAIL ack_latch got %h want DF", bus.int_vector); end
        bus.ym_irq_n = 0;
        tick();
        checks++; if (bus.int_vector !== 8'hDF) begin errors++; $display("FAIL ack_held got %h want DF", bus.int_vector); end
        bus.z80_m1_n = 1; bus.z80_iorq_n = 1;
        tick();
        checks++; if (bus.int_vector !== 8'hFF) begin errors++; $display("FAIL ack_idle got %h want FF", bus.int_vector); end
        bus.z80_m1_n = 0; bus.z80_iorq_n = 0;
        tick();
        checks++; if (bus.int_vector !== 8'hCF) begin errors++; $display("FAIL ack_both got %h want CF", bus.int_vector); end
        bus.z80_m1_n = 1; bus.z80_iorq_n = 1;
        checks++; if (bus.main_pending !== 1'b1) begin errors++; $display("FAIL ack_keeps_pending got %b want 1", bus.main_pending); end
        bus.snd_clr = 1; tick(); bus.snd_clr = 0;
        checks++; if (bus.main_pending !== 1'b0) begin errors++; $display("FAIL clr_pending got %b want 0", bus.main_pending); end
        tick();
        checks++; if (bus.z80_int_n !== 1'b0) begin errors++; $display("FAIL ym_keeps_int got %b want 0", bus.z80_int_n); end
        bus.ym_irq_n = 1;
        tick(); tick();
    endtask

    task automatic test_ym_only();
        bus.ym_irq_n = 0;
        tick();
        checks++; if (bus.z80_int_n !== 1'b0) begin errors++; $display("FAIL ym_int got %b want 0", bus.z80_int_n); end
        bus.z80_m1_n = 0; bus.z80_iorq_n = 0;
        tick();
        checks++; if (bus.int_vector !== 8'hEF) begin errors++; $display("FAIL ym_vector got %h want EF", bus.int_vector); end
        bus.z80_m1_n = 1; bus.z80_iorq_n = 1; bus.ym_irq_n = 1;
        tick();
        checks++; if (bus.z80_int_n !== 1'b1) begin errors++; $display("FAIL ym_release got %b want 1", bus.z80_int_n); end
    endtask

    task automatic test_set_clear_same();
        bus.main_din = 8'h11; bus.main_wr = 1; tick(); bus.main_wr = 0; tick();
        bus.main_din = 8'h55; bus.main_wr = 1; bus.snd_clr = 1;
        tick();
        checks++; if (bus.main_pending !== 1'b1) begin errors++; $display("FAIL setclr_pending got %b want 1", bus.main_pending); end
        checks++; if (bus.snd_dout !== 8'h55) begin errors++; $display("FAIL setclr_cmd got %h want 55", bus.snd_dout); end
        bus.main_wr = 0; bus.snd_clr = 0; tick();
        bus.snd_clr = 1; tick(); bus.snd_clr = 0; tick();
        checks++; if (bus.main_pending !== 1'b0) begin errors++; $display("FAIL clr_after got %b want 0", bus.main_pending); end
    endtask
`else
    task automatic test_fifo();
        for (int i = 1; i <= 5; i++) begin
            bus.main_din = 8'(i); bus.main_wr = 1; tick(); bus.main_wr = 0; tick();
        end
        checks++; if (bus.main_pending !== 1'b1) begin errors++; $display("FAIL fifo_pending got %b want 1", bus.main_pending); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.snd_dout !== 8'(i)) begin errors++; $display("FAIL fifo_pop%0d got %h want %h", i, bus.snd_dout, 8'(i)); end
            bus.snd_clr = 1; tick(); bus.snd_clr = 0; tick();
        end
        checks++; if (bus.main_pending !== 1'b0) begin errors++; $display("FAIL fifo_empty got %b want 0", bus.main_pending); end
        checks++; if (bus.snd_dout !== 8'h00) begin errors++; $display("FAIL fifo_empty_dout got %h want 00", bus.snd_dout); end
        bus.snd_clr = 1; tick(); bus.snd_clr = 0; tick();
        bus.main_din = 8'hA5; bus.main_wr = 1; tick(); bus.main_wr = 0; tick();
        checks++; if (bus.snd_dout !== 8'hA5) begin errors++; $display("FAIL fifo_wrap got %h want A5", bus.snd_dout); end
        bus.snd_clr = 1; tick(); bus.snd_clr = 0; tick();
    endtask
`endif

    task automatic test_reply_reset();
        bus.snd_din = 8'h81; bus.snd_reply_wr = 1; tick(); bus.snd_reply_wr = 0;
        checks++; if (bus.main_dout !== 8'h81) begin errors++; $display("FAIL reply got %h want 81", bus.main_dout); end
        bus.main_din = 8'h42; bus.main_wr = 1; tick(); bus.main_wr = 0; tick();
        checks++; if (bus.z80_int_n !== 1'b0) begin errors++; $display("FAIL pre_reset_int got %b want 0", bus.z80_int_n); end
        #1 reset_n = 0;
        #1;
        checks++; if (bus.main_dout !== 8'hFF) begin errors++; $display("FAIL async_reply got %h want FF", bus.main_dout); end
        checks++; if (bus.z80_int_n !== 1'b1) begin errors++; $display("FAIL async_int got %b want 1", bus.z80_int_n); end
        checks++; if (bus.main_pending !== 1'b0) begin errors++; $display("FAIL async_pending got %b want 0", bus.main_pending); end
        checks++; if (bus.snd_dout !== 8'h00) begin errors++; $display("FAIL async_cmd got %h want 00", bus.snd_dout); end
        tick();
        reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
`ifndef SND_LATCH_FIFO_EN
        test_cmd_write();
        test_ack();
        test_ym_only();
        test_set_clear_same();
`else
        test_fifo();
`endif
        test_reply_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
